mem_bus_responder: RTL

Memory-side responder for the core's `req`/`addr_ok`/`data_ok` memory bus. It sits behind the core's ROM/RAM arbiter as the single target of its `mem_*` port. It owns a word-organised, byte-maskable on-chip memory and acknowledges each request with `mem_addr_ok` in the issue cycle. It returns `mem_data_ok` (with `mem_rdata` for reads) a fixed, configurable number of cycles later, in request order.

---
 rtl/mem_bus_responder_pkg.sv | 20 ++
 rtl/mem_bus_responder_sram.sv | 36 +++
 rtl/mem_bus_responder.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared widths and pipeline types for the memory-bus responder and its storage array.
package mem_bus_responder_pkg;

  localparam int BUS_WIDTH      = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int RAM_MASK_WIDTH = DATA_WIDTH / 8;

  // Control half of a response-pipeline stage; read data travels separately.
  typedef struct packed {
    logic valid;
    logic we;
  } stage_ctrl_t;

  // Byte span of a 2**depth_log2-word memory, one bit wider than the bus so the
  // range compare stays correct even when the memory covers the whole space.
  function automatic logic [BUS_WIDTH:0] byte_span(input int depth_log2);
    return (BUS_WIDTH + 1)'(4) << depth_log2;
  endfunction

endpackage

// File: rtl/mem_bus_responder_sram.sv
// Single-port word memory with per-byte write enables and a registered,
// read-old-data output, written so synthesis can map it onto block RAM.
module sram_bytemask_array
  import mem_bus_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [DEPTH_LOG2-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [RAM_MASK_WIDTH-1:0] wmask,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem_array [1 << DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // The read samples the array before this edge's byte writes land.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_reg <= mem_array[addr];
      if (we) begin
        for (int b = 0; b < RAM_MASK_WIDTH; b++) begin
          if (wmask[b]) begin
            mem_array[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: accepts req/addr_ok requests into an on-chip byte-maskable
// memory and answers each with data_ok a fixed number of cycles later, in order.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int                   DEPTH_LOG2  = 12,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                   LATENCY     = 1,
  parameter int                   OUTSTANDING = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_hold_i,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [BUS_WIDTH-1:0]      mem_address,
  input  logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_MASK_WIDTH-1:0] mem_wmask,
  output logic                      mem_addr_ok,
  output logic                      mem_data_ok,
  output logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      err_o
);

  localparam logic [BUS_WIDTH:0] SPAN = byte_span(DEPTH_LOG2);

  stage_ctrl_t           ctrl_reg [LATENCY];
  logic                  oor_reg;
  logic                  err_reg;
  logic [BUS_WIDTH-1:0]  offset;
  logic                  out_of_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  accept;
  logic                  retire;
  int                    occupancy;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic [DATA_WIDTH-1:0] rdata_chain [LATENCY];

  assign offset       = mem_address - BASE_ADDR;
  assign out_of_range = {1'b0, offset} >= SPAN;
  assign word_idx     = offset[DEPTH_LOG2+1:2];

  assign retire = rst_n & ctrl_reg[LATENCY-1].valid & ~mem_hold_i;

  // A slot freed by this cycle's retirement can be reused by this cycle's request.
  always_comb begin
    occupancy = 0;
    for (int i = 0; i < LATENCY; i++) begin
      occupancy += int'(ctrl_reg[i].valid);
    end
    occupancy -= int'(retire);
  end

  assign accept = rst_n & mem_req & ~mem_hold_i & (occupancy < OUTSTANDING);

  sram_bytemask_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (accept & ~out_of_range),
    .we   (mem_we),
    .addr (word_idx),
    .wdata(mem_wdata),
    .wmask(mem_wmask),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        ctrl_reg[i] <= '0;
      end
      oor_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      if (accept && out_of_range) begin
        err_reg <= 1'b1;
      end
      if (!mem_hold_i) begin
        ctrl_reg[0] <= '{valid: accept, we: mem_we};
        for (int i = 1; i < LATENCY; i++) begin
          ctrl_reg[i] <= ctrl_reg[i-1];
        end
        oor_reg <= out_of_range;
      end
    end
  end

  // Stage 0 data is the array's output register; an out-of-range read never
  // touched the array, so its stale output is replaced by zero here.
  assign rdata_chain[0] = oor_reg ? '0 : sram_rdata;

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    logic [DATA_WIDTH-1:0] rdata_reg;
    always_ff @(posedge clk) begin
      if (!mem_hold_i) begin
        rdata_reg <= rdata_chain[gi-1];
      end
    end
    assign rdata_chain[gi] = rdata_reg;
  end

  assign mem_addr_ok = accept;
  assign mem_data_ok = retire;
  assign mem_rdata   = (retire && !ctrl_reg[LATENCY-1].we) ? rdata_chain[LATENCY-1] : '0;
  assign err_o       = err_reg;

endmodule
